// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind the UART byte receiver: SOF, LEN, payload, XOR checksum.
// Buffers one payload and streams it out on valid/ready only after the checksum matches.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SOF_BYTE     = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        err_pulse,
  output logic [2:0]  err_code,
  output logic [15:0] pkt_count
);

  // Output stream: out_valid/out_data/out_last are held until out_valid && out_ready.
  localparam int          IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CLKS - 1);

  localparam logic [2:0] ERR_FRAME   = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_CHK     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_OVERRUN = 3'd5;

  typedef enum logic [2:0] {
    ST_SOF,
    ST_LEN,
    ST_PAY,
    ST_CHK,
    ST_OUT
  } state_t;

  state_t      state, state_d;
  logic [7:0]  len, len_d;
  logic [7:0]  idx, idx_d;
  logic [7:0]  xor_acc, xor_d;
  logic [15:0] tmo_cnt, tmo_d;
  logic        out_valid_d, out_last_d, err_pulse_d, wr_en;
  logic [7:0]  out_data_d;
  logic [2:0]  err_code_d;
  logic [15:0] pkt_count_d;
  logic [7:0]  len_m1, idx_p1;

  logic [7:0] buf_mem [0:(1<<IW)-1];

  assign len_m1 = len - 8'd1;
  assign idx_p1 = idx + 8'd1;

  always_comb begin
    state_d     = state;
    len_d       = len;
    idx_d       = idx;
    xor_d       = xor_acc;
    tmo_d       = tmo_cnt;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    out_data_d  = out_data;
    err_pulse_d = 1'b0;
    err_code_d  = err_code;
    pkt_count_d = pkt_count;
    wr_en       = 1'b0;

    case (state)
      ST_SOF: begin
        if (rx_err) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_FRAME;
        end else if (rx_valid && rx_data == SOF_BYTE) begin
          state_d = ST_LEN;
          xor_d   = '0;
          idx_d   = '0;
          tmo_d   = '0;
        end
      end

      ST_LEN, ST_PAY, ST_CHK: begin
        tmo_d = tmo_cnt + 16'd1;
        if (rx_err) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_FRAME;
          state_d     = ST_SOF;
          tmo_d       = '0;
        end else if (rx_valid) begin
          tmo_d = '0;
          if (state == ST_LEN) begin
            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
              err_pulse_d = 1'b1;
              err_code_d  = ERR_LEN;
              state_d     = ST_SOF;
            end else begin
              len_d   = rx_data;
              xor_d   = rx_data;
              idx_d   = '0;
              state_d = ST_PAY;
            end
          end else if (state == ST_PAY) begin
            wr_en = 1'b1;
            xor_d = xor_acc ^ rx_data;
            if (idx == len_m1) state_d = ST_CHK;
            else               idx_d   = idx_p1;
          end else begin
            if (rx_data == xor_acc) begin
              state_d = ST_OUT;
              idx_d   = '0;
            end else begin
              err_pulse_d = 1'b1;
              err_code_d  = ERR_CHK;
              state_d     = ST_SOF;
            end
          end
        end else if (tmo_cnt == TMO_LAST) begin
          // An event on the expiry cycle takes the branch above instead.
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_SOF;
          tmo_d       = '0;
        end
      end

      ST_OUT: begin
        if (rx_valid || rx_err) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
        if (!out_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = buf_mem[idx[IW-1:0]];
          out_last_d  = (idx == len_m1);
        end else if (out_ready) begin
          if (out_last) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            pkt_count_d = pkt_count + 16'd1;
            state_d     = ST_SOF;
          end else begin
            idx_d      = idx_p1;
            out_data_d = buf_mem[idx_p1[IW-1:0]];
            out_last_d = (idx_p1 == len_m1);
          end
        end
      end

      default: state_d = ST_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_SOF;
      len       <= '0;
      idx       <= '0;
      xor_acc   <= '0;
      tmo_cnt   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      err_pulse <= 1'b0;
      err_code  <= '0;
      pkt_count <= '0;
    end else begin
      state     <= state_d;
      len       <= len_d;
      idx       <= idx_d;
      xor_acc   <= xor_d;
      tmo_cnt   <= tmo_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      out_data  <= out_data_d;
      err_pulse <= err_pulse_d;
      err_code  <= err_code_d;
      pkt_count <= pkt_count_d;
    end
  end

  // Payload store; contents are don't-care until rewritten by the next frame.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[idx[IW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Bench for uart_rx_pkt_ctrl: directed and random frames checked against a
// queue-based packet model (expected output bytes, expected error codes, packet count).
module tb_uart_rx_pkt_ctrl;

  localparam logic [7:0] SOF      = 8'hA5;
  localparam int         MAX_LEN  = 16;
  localparam int         TIMEOUT  = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_err = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1'b0;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic [15:0] pkt_count;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [8:0] exp_q[$];      // {last, data}
  logic [2:0] exp_err_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] pay_q[$];
  int         exp_pkts = 0;
  int         ready_mode = 0;  // 0 always, 1 random, 2 pattern 1,0,0,1, 3 never
  logic [3:0] pat = 4'b1001;
  int         pat_i = 0;

  uart_rx_pkt_ctrl #(.SOF_BYTE(SOF), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .err_pulse(err_pulse), .err_code(err_code), .pkt_count(pkt_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Consumer: out_ready changes just after the rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        out_ready = pat[pat_i];
        pat_i = (pat_i + 1) % 4;
      end
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard: stream bytes, stall stability and error codes
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      logic [8:0] e;
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (err_pulse) begin
        if (exp_err_q.size() == 0) chk("unexpected_err_pulse", 32'(err_pulse), 32'd0);
        else chk("err_code", 32'(err_code), 32'(exp_err_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e[7:0]));
          chk("out_last", 32'(out_last), 32'(e[8]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Driver: sends tx_q starting at a falling edge, random idle gaps between bytes.
  task automatic send_tx(input int max_gap);
    while (tx_q.size() > 0) begin
      rx_data  = tx_q.pop_front();
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      if (tx_q.size() > 0 && max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic rand_pay(input int n);
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Model: checksum is LEN xor all payload bytes; good frames stream the payload.
  task automatic frame_pkt(input bit good, input int max_gap);
    logic [7:0] x;
    int n;
    n = pay_q.size();
    x = 8'(n);
    tx_q.push_back(SOF);
    tx_q.push_back(8'(n));
    foreach (pay_q[i]) begin
      x = x ^ pay_q[i];
      tx_q.push_back(pay_q[i]);
      if (good) exp_q.push_back({(i == n - 1), pay_q[i]});
    end
    if (good) begin
      tx_q.push_back(x);
      exp_pkts++;
    end else begin
      tx_q.push_back(x ^ 8'($urandom_range(1, 255)));
      exp_err_q.push_back(3'd3);
    end
    pay_q.delete();
    send_tx(max_gap);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || out_valid); i++) @(negedge clk);
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    chk("err_outstanding", 32'(exp_err_q.size()), 32'd0);
    chk("pkt_count", 32'(pkt_count), 32'(exp_pkts));
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Good packet, back-to-back bytes, first out_valid one clock after checksum
    ready_mode = 0;
    pay_q = '{8'h11, 8'h22, 8'h33};
    frame_pkt(1'b1, 0);
    chk("latency_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_data", 32'(out_data), 32'h11);
    wait_drain();

    // Bad checksum, then a good single-byte packet
    tx_q = '{SOF, 8'h02, 8'hAA, 8'h55, 8'h00};
    exp_err_q.push_back(3'd3);
    send_tx(1);
    pay_q = '{8'h7E};
    frame_pkt(1'b1, 1);
    wait_drain();

    // Length boundaries
    tx_q = '{SOF, 8'h00};
    exp_err_q.push_back(3'd2);
    send_tx(0);
    tx_q = '{SOF, 8'(MAX_LEN + 1)};
    exp_err_q.push_back(3'd2);
    send_tx(0);
    wait_drain();
    chk("len_err_code_held", 32'(err_code), 32'd2);
    rand_pay(MAX_LEN);
    frame_pkt(1'b1, 0);
    wait_drain();

    // Timeout fires on the 400th idle clock
    tx_q = '{SOF, 8'h02, 8'h10};
    exp_err_q.push_back(3'd4);
    send_tx(0);
    for (int k = 1; k < TIMEOUT; k++) begin
      @(negedge clk);
      chk("tmo_quiet", 32'(err_pulse), 32'd0);
    end
    @(negedge clk);
    chk("tmo_pulse", 32'(err_pulse), 32'd1);
    chk("tmo_code", 32'(err_code), 32'd4);
    wait_drain();

    // Byte on the expiry cycle wins over the timeout
    tx_q = '{SOF, 8'h02, 8'h10};
    send_tx(0);
    repeat (TIMEOUT - 1) @(negedge clk);
    tx_q = '{8'h20, 8'h32};
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b1, 8'h20});
    exp_pkts++;
    send_tx(0);
    wait_drain();

    // Backpressure pattern and overrun during streaming
    ready_mode = 2;
    pay_q = '{8'hC1, 8'hC2, 8'hC3};
    frame_pkt(1'b1, 0);
    tx_q = '{SOF, 8'h01};
    exp_err_q.push_back(3'd5);
    exp_err_q.push_back(3'd5);
    send_tx(0);
    wait_drain();
    chk("overrun_code_held", 32'(err_code), 32'd5);
    ready_mode = 0;

    // Framing error mid-payload, and rx_valid+rx_err together
    tx_q = '{SOF, 8'h03, 8'h11};
    send_tx(0);
    rx_err = 1'b1;
    exp_err_q.push_back(3'd1);
    @(negedge clk);
    rx_err = 1'b0;
    rx_data = SOF; rx_valid = 1'b1; rx_err = 1'b1;
    exp_err_q.push_back(3'd1);
    @(negedge clk);
    rx_valid = 1'b0; rx_err = 1'b0;
    pay_q = '{8'h5A, 8'h6B};
    frame_pkt(1'b1, 1);
    wait_drain();

    // Random frames with noise, random gaps and random consumer
    ready_mode = 1;
    for (int p = 0; p < 20; p++) begin
      repeat ($urandom_range(0, 3)) tx_q.push_back(8'($urandom_range(0, 8'hA4)));
      send_tx(1);
      rand_pay($urandom_range(1, MAX_LEN));
      frame_pkt($urandom_range(0, 4) != 0, 2);
      wait_drain();
    end

    // Reset while a packet is stalled in the output stage
    ready_mode = 3;
    pay_q = '{8'hD1, 8'hD2, 8'hD3};
    frame_pkt(1'b1, 0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_valid", 32'(out_valid), 32'd0);
    chk("mid_reset_pkt_count", 32'(pkt_count), 32'd0);
    chk("mid_reset_err_pulse", 32'(err_pulse), 32'd0);
    exp_q.delete();
    exp_pkts = 0;
    reset = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    pay_q = '{8'hE7};
    frame_pkt(1'b1, 0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
